// File: rtl/alu_add_seq_pkg.sv
// Shared constants, FSM state type and carry-lookahead helpers for alu_add_seq.
// Optional subtract support is enabled by defining ALU_ADD_SEQ_SUB_EN.
package alu_add_seq_pkg;

    localparam int SLICE_W   = 16;
    localparam int BEATS_MIN = 2;
    localparam int BEATS_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Group generate/propagate of four (g, p) pairs, returned as {G, P}.
    function automatic logic [1:0] group_gp(input logic [3:0] g, input logic [3:0] p);
        logic w_gg;
        w_gg = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        return {w_gg, &p};
    endfunction

    // Carries into positions 0..3 of a four-wide lookahead block.
    function automatic logic [3:0] group_carries(input logic [3:0] g, input logic [3:0] p,
                                                 input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/alu_add_seq_cla16.sv
// 16-bit two-level carry-lookahead adder with group generate/propagate outputs.
// Module name cla_add16 is the shared adder reused by other blocks.
module cla_add16
    import alu_add_seq_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_ci,
    output logic [15:0] o_s,
    output logic        o_g,
    output logic        o_p
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_grp_g;
    logic [3:0]  w_grp_p;
    logic [3:0]  w_grp_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    for (genvar n = 0; n < 4; n++) begin : g_nibble
        assign {w_grp_g[n], w_grp_p[n]} = group_gp(w_g[4*n +: 4], w_p[4*n +: 4]);
        assign w_c[4*n +: 4]            = group_carries(w_g[4*n +: 4], w_p[4*n +: 4], w_grp_c[n]);
    end

    // The second lookahead level reuses the same carry equations over the nibble groups.
    assign w_grp_c    = group_carries(w_grp_g, w_grp_p, i_ci);
    assign {o_g, o_p} = group_gp(w_grp_g, w_grp_p);
    assign o_s        = w_p ^ w_c;

endmodule

// File: rtl/alu_add_seq.sv
// Multi-beat add/subtract: one shared 16-bit CLA processes one slice per cycle.
// Define ALU_ADD_SEQ_SUB_EN to honour req_sub; otherwise every operation is an add.
module alu_add_seq
    import alu_add_seq_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SLICE_W*BEATS-1:0] req_a,
    input  logic [SLICE_W*BEATS-1:0] req_b,
    input  logic                     req_ci,
    input  logic                     req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [SLICE_W*BEATS-1:0] rsp_s,
    output logic                     rsp_co,
    output logic                     rsp_v,
    output logic                     busy
);

    localparam int            W      = SLICE_W * BEATS;
    localparam int            KW     = $clog2(BEATS);
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

    if (BEATS < BEATS_MIN || BEATS > BEATS_MAX) begin : g_beats_range
        $error("alu_add_seq: BEATS must lie in 2..8");
    end

    state_t                         r_state;
    logic [KW-1:0]                  r_k;
    logic                           r_c;
    logic                           r_co;
    logic                           r_v;
    logic                           r_req_ready;
    logic                           r_rsp_valid;
    logic                           r_busy;
    logic [BEATS-1:0][SLICE_W-1:0]  r_a;
    logic [BEATS-1:0][SLICE_W-1:0]  r_b;
    logic [BEATS-1:0][SLICE_W-1:0]  r_s;

    logic                           w_sub;
    logic                           w_c_init;
    logic                           w_accept;
    logic [W-1:0]                   w_b_prime;
    logic [SLICE_W-1:0]             w_a_slice;
    logic [SLICE_W-1:0]             w_b_slice;
    logic [SLICE_W-1:0]             w_sum;
    logic                           w_g;
    logic                           w_p;
    logic                           w_c_next;
    logic                           w_ovf;

`ifdef ALU_ADD_SEQ_SUB_EN
    assign w_sub = req_sub;
`else
    logic w_unused_sub;
    assign w_unused_sub = req_sub;
    assign w_sub        = 1'b0;
`endif

    // Subtract is A + ~B + 1, so the carry-in is forced high and req_ci drops out.
    assign w_b_prime = w_sub ? ~req_b : req_b;
    assign w_c_init  = w_sub | req_ci;
    assign w_accept  = req_valid && (r_state == ST_IDLE);

    assign w_a_slice = r_a[r_k];
    assign w_b_slice = r_b[r_k];

    cla_add16 u_cla (
        .i_a  (w_a_slice),
        .i_b  (w_b_slice),
        .i_ci (r_c),
        .o_s  (w_sum),
        .o_g  (w_g),
        .o_p  (w_p)
    );

    assign w_c_next = w_g | (w_p & r_c);
    // Only meaningful on the last beat, where the slice holds the operand sign bits.
    assign w_ovf    = (w_a_slice[SLICE_W-1] == w_b_slice[SLICE_W-1]) &&
                      (w_sum[SLICE_W-1] != w_a_slice[SLICE_W-1]);

    // NOTE: operand registers are not reset; they are always reloaded on accept
    // before they are read, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= req_a;
            r_b <= w_b_prime;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_c         <= 1'b0;
            r_s         <= '0;
            r_co        <= 1'b0;
            r_v         <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_k         <= '0;
                        r_c         <= w_c_init;
                        r_state     <= ST_RUN;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_s[r_k] <= w_sum;
                    r_c      <= w_c_next;
                    r_k      <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_co        <= w_c_next;
                        r_v         <= w_ovf;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign busy      = r_busy;
    assign rsp_s     = r_s;
    assign rsp_co    = r_co;
    assign rsp_v     = r_v;

endmodule

// File: tb/tb_alu_add_seq.sv
// Self-checking bench for alu_add_seq (BEATS=4) against an arithmetic reference model.
// Expectations follow ALU_ADD_SEQ_SUB_EN the same way the design build does.
module tb_alu_add_seq;

    localparam int BEATS = 4;
    localparam int W     = 16 * BEATS;
`ifdef ALU_ADD_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam logic signed [W+1:0] MAXS = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MINS = {3'b111, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         v;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        res_t         exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_ci;
    logic         req_sub;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_s;
    logic         rsp_co;
    logic         rsp_v;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_add_seq #(.BEATS(BEATS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co),
        .rsp_v     (rsp_v),
        .busy      (busy)
    );

    // Reference: plain integer arithmetic; overflow means the signed result leaves W-bit range.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sub);
        res_t                r;
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb;
        logic signed [W+1:0] sr;
        logic [W:0]          ur;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (SUB_EN && sub) begin
            r.s  = a - b;
            r.co = (a >= b);
            sr   = sa - sb;
        end else begin
            ur   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r.s  = ur[W-1:0];
            r.co = ur[W];
            sr   = sa + sb + {{(W+1){1'b0}}, ci};
        end
        r.v = (sr > MAXS) || (sr < MINS);
        return r;
    endfunction

    // Drive one request, scramble req_* after accept, wait (bounded) for rsp_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sub, output res_t got, output int lat, output int waited);
        req_a     = a;
        req_b     = b;
        req_ci    = ci;
        req_sub   = sub;
        req_valid = 1'b1;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_ci    = 1'($urandom);
        req_sub   = 1'($urandom);
        lat       = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = '{s: rsp_s, co: rsp_co, v: rsp_v};
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+4:0] obs;
        reset     = 1'b1;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        req_a     = '1;
        req_b     = '1;
        req_ci    = 1'b1;
        req_sub   = 1'b0;
        @(posedge clk); #1;
        obs = {req_ready, rsp_valid, busy, rsp_co, rsp_v, rsp_s};
        total++;
        if (obs !== {5'b10000, {W{1'b0}}}) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs, {5'b10000, {W{1'b0}}});
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        obs = {req_ready, rsp_valid, busy, rsp_co, rsp_v, rsp_s};
        total++;
        if (obs !== {5'b10000, {W{1'b0}}}) begin
            bad++;
            $display("FAIL reset_idle_hold got=%h exp=%h", obs, {5'b10000, {W{1'b0}}});
        end
    endtask

    task automatic test_directed();
        vec_t tab[6];
        res_t got;
        int   lat;
        int   waited;
        tab[0] = '{a: '1, b: 64'd1, ci: 1'b0, sub: 1'b0, exp: '{s: '0, co: 1'b1, v: 1'b0}};
        tab[1] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, ci: 1'b0, sub: 1'b0,
                   exp: '{s: 64'h8000_0000_0000_0000, co: 1'b0, v: 1'b1}};
        tab[2] = '{a: 64'h0000_FFFF_0000_FFFF, b: 64'd0, ci: 1'b1, sub: 1'b0,
                   exp: '{s: 64'h0000_FFFF_0001_0000, co: 1'b0, v: 1'b0}};
        tab[3] = '{a: 64'd5, b: 64'd7, ci: 1'b0, sub: 1'b1,
                   exp: SUB_EN ? '{s: 64'hFFFF_FFFF_FFFF_FFFE, co: 1'b0, v: 1'b0}
                               : '{s: 64'd12, co: 1'b0, v: 1'b0}};
        tab[4] = '{a: 64'd5, b: 64'd7, ci: 1'b1, sub: 1'b1,
                   exp: SUB_EN ? '{s: 64'hFFFF_FFFF_FFFF_FFFE, co: 1'b0, v: 1'b0}
                               : '{s: 64'd13, co: 1'b0, v: 1'b0}};
        tab[5] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, ci: 1'b0, sub: 1'b1,
                   exp: SUB_EN ? '{s: 64'h7FFF_FFFF_FFFF_FFFF, co: 1'b1, v: 1'b1}
                               : '{s: 64'h8000_0000_0000_0001, co: 1'b0, v: 1'b0}};
        for (int i = 0; i < 6; i++) begin
            run_op(tab[i].a, tab[i].b, tab[i].ci, tab[i].sub, got, lat, waited);
            total++;
            if (got !== tab[i].exp) begin
                bad++;
                $display("FAIL directed_%0d result got=%h exp=%h", i, got, tab[i].exp);
            end
            total++;
            if (lat !== BEATS) begin
                bad++;
                $display("FAIL directed_%0d latency got=%0d exp=%0d", i, lat, BEATS);
            end
            release_rsp();
            total++;
            if ({req_ready, rsp_valid, busy} !== 3'b100) begin
                bad++;
                $display("FAIL directed_%0d to_idle got=%b exp=100", i, {req_ready, rsp_valid, busy});
            end
        end
    endtask

    task automatic test_random();
        res_t         got;
        res_t         exp;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        int           lat;
        int           waited;
        int           hold;
        for (int i = 0; i < 40; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            ci  = 1'($urandom);
            sub = 1'($urandom);
            case ($urandom_range(0, 3))
                0: b = ~a;
                1: a = {$urandom_range(0, 1) == 0 ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 32'hFFFF_FFFF};
                2: b = a;
                default: ;
            endcase
            exp = model(a, b, ci, sub);
            run_op(a, b, ci, sub, got, lat, waited);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h ci=%b sub=%b got=%h exp=%h",
                         i, a, b, ci, sub, got, exp);
            end
            total++;
            if (lat !== BEATS) begin
                bad++;
                $display("FAIL random_%0d latency got=%0d exp=%0d", i, lat, BEATS);
            end
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(posedge clk); #1;
            end
            release_rsp();
        end
    endtask

    task automatic test_backpressure();
        res_t           got;
        res_t           exp;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W+4:0]   obs;
        int             lat;
        int             waited;
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        exp = model(a, b, 1'b1, 1'b0);
        run_op(a, b, 1'b1, 1'b0, got, lat, waited);
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_a     = {$urandom, $urandom};
            obs = {rsp_valid, req_ready, busy, rsp_s, rsp_co, rsp_v};
            total++;
            if (obs !== {3'b101, exp}) begin
                bad++;
                $display("FAIL backpressure_cycle%0d got=%h exp=%h", i, obs, {3'b101, exp});
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        release_rsp();
        total++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL backpressure_release got=%b exp=100", {req_ready, rsp_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        res_t         got;
        res_t         exp;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        int           lat;
        int           waited;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            ci  = 1'($urandom);
            exp = model(a, b, ci, 1'b0);
            run_op(a, b, ci, 1'b0, got, lat, waited);
            total++;
            if (got !== exp || lat !== BEATS) begin
                bad++;
                $display("FAIL b2b_%0d got=%h lat=%0d exp=%h lat=%0d", i, got, lat, exp, BEATS);
            end
            total++;
            if (waited !== (i == 0 ? 0 : 1)) begin
                bad++;
                $display("FAIL b2b_%0d idle_gap got=%0d exp=%0d", i, waited, i == 0 ? 0 : 1);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_final_idle got=%b exp=100", {req_ready, rsp_valid, busy});
        end
    endtask

    task automatic test_reset_midrun();
        res_t         got;
        res_t         exp;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+4:0] obs;
        int           lat;
        int           waited;
        int           seen;
        req_a     = '1;
        req_b     = 64'd1;
        req_ci    = 1'b0;
        req_sub   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        obs = {req_ready, rsp_valid, busy, rsp_co, rsp_v, rsp_s};
        total++;
        if (obs !== {5'b10000, {W{1'b0}}}) begin
            bad++;
            $display("FAIL midrun_reset_state got=%h exp=%h", obs, {5'b10000, {W{1'b0}}});
        end
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrun_no_response got=%0d exp=0", seen);
        end
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        exp = model(a, b, 1'b0, 1'b1);
        run_op(a, b, 1'b0, 1'b1, got, lat, waited);
        total++;
        if (got !== exp || lat !== BEATS) begin
            bad++;
            $display("FAIL midrun_next_op got=%h lat=%0d exp=%h lat=%0d", got, lat, exp, BEATS);
        end
        release_rsp();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
